// File: rtl/memory_stage.sv
// Memory stage: runs one EX/MEM request against a 16-bit synchronous data memory, splitting 32-bit PC stack traffic into two word accesses.
// Latency: 1 cycle with no access, 2 for a single write, 3 for a PC push or single read, 4 for a PC pop (accept edge to Valid_Out).
// Backpressure: Stall is high whenever the FSM is not IDLE; upstream buffers hold and Valid_In is ignored until it drops.
module memory_stage #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Valid_In,
  input  logic              MR,
  input  logic              MW,
  input  logic              WB,
  input  logic [2:0]        WB_Address,
  input  logic [31:0]       Data,
  input  logic [31:0]       Address,
  input  logic              Stack_PC,
  input  logic              Stack_Flags,
  input  logic [2:0]        Final_Flags,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  output logic              Mem_WE,
  output logic              Mem_RE,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              Stall,
  output logic              Valid_Out,
  output logic              WB_Out,
  output logic [2:0]        WB_Address_Out,
  output logic [DATA_W-1:0] WB_Data,
  output logic [31:0]       PC_Out,
  output logic              PC_Valid,
  output logic [2:0]        Flags_Out,
  output logic              Flags_Valid
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_HI   = 3'd1;
  localparam logic [2:0] WR_LO   = 3'd2;
  localparam logic [2:0] RD_LO   = 3'd3;
  localparam logic [2:0] RD_HI   = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [2:0]        state;
  logic              wb_r;
  logic [2:0]        wb_addr_r;
  logic [31:0]       data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              stack_pc_r;
  logic              stack_flags_r;
  logic [2:0]        flags_r;
  logic [DATA_W-1:0] lo_r;

  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_dec;
  logic [DATA_W-1:0] data_lo;
  logic [DATA_W-1:0] data_hi;
  logic [DATA_W-1:0] flags_word;

  // Only the low ADDR_W address bits select a memory word.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:ADDR_W];

  // Stack neighbours wrap modulo the memory size by construction of the width.
  assign addr_inc   = addr_r + ADDR_ONE;
  assign addr_dec   = addr_r - ADDR_ONE;
  assign data_lo    = data_r[DATA_W-1:0];
  assign data_hi    = data_r[2*DATA_W-1:DATA_W];
  assign flags_word = {{(DATA_W-3){1'b0}}, flags_r};

  assign Stall = (state != IDLE);

  // Memory port is decoded from the state alone so a reset drops WE/RE at once.
  always_comb begin
    Mem_Addr  = '0;
    Mem_Wdata = '0;
    Mem_WE    = 1'b0;
    Mem_RE    = 1'b0;
    case (state)
      WR_HI: begin
        Mem_WE    = 1'b1;
        Mem_Addr  = addr_r;
        Mem_Wdata = data_hi;
      end
      WR_LO: begin
        Mem_WE    = 1'b1;
        Mem_Addr  = stack_pc_r ? addr_dec : addr_r;
        if (!stack_pc_r && stack_flags_r) Mem_Wdata = flags_word;
        else                              Mem_Wdata = data_lo;
      end
      RD_LO: begin
        Mem_RE   = 1'b1;
        Mem_Addr = addr_r;
      end
      RD_HI: begin
        Mem_RE   = 1'b1;
        Mem_Addr = addr_inc;
      end
      default: ;
    endcase
  end

  // Request capture, access sequencing and registered write-back results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wb_r           <= 1'b0;
      wb_addr_r      <= '0;
      data_r         <= '0;
      addr_r         <= '0;
      stack_pc_r     <= 1'b0;
      stack_flags_r  <= 1'b0;
      flags_r        <= '0;
      lo_r           <= '0;
      Valid_Out      <= 1'b0;
      WB_Out         <= 1'b0;
      WB_Address_Out <= '0;
      WB_Data        <= '0;
      PC_Out         <= '0;
      PC_Valid       <= 1'b0;
      Flags_Out      <= '0;
      Flags_Valid    <= 1'b0;
    end else begin
      Valid_Out   <= 1'b0;
      PC_Valid    <= 1'b0;
      Flags_Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Valid_In) begin
            wb_r          <= WB;
            wb_addr_r     <= WB_Address;
            data_r        <= Data;
            addr_r        <= Address[ADDR_W-1:0];
            stack_pc_r    <= Stack_PC;
            stack_flags_r <= Stack_Flags;
            flags_r       <= Final_Flags;
            // A write wins over a simultaneous read.
            if (MW) begin
              state <= Stack_PC ? WR_HI : WR_LO;
            end else if (MR) begin
              state <= RD_LO;
            end else begin
              Valid_Out      <= 1'b1;
              WB_Out         <= WB;
              WB_Address_Out <= WB_Address;
              WB_Data        <= Data[DATA_W-1:0];
            end
          end
        end
        WR_HI: state <= WR_LO;
        WR_LO: begin
          state          <= IDLE;
          Valid_Out      <= 1'b1;
          WB_Out         <= wb_r;
          WB_Address_Out <= wb_addr_r;
          WB_Data        <= data_lo;
        end
        RD_LO: state <= stack_pc_r ? RD_HI : RD_WAIT;
        RD_HI: begin
          // Read data of RD_LO (the low word at A) is on Mem_Rdata now.
          lo_r  <= Mem_Rdata;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          state          <= IDLE;
          Valid_Out      <= 1'b1;
          WB_Out         <= wb_r;
          WB_Address_Out <= wb_addr_r;
          if (stack_pc_r) begin
            WB_Data  <= lo_r;
            PC_Out   <= {Mem_Rdata, lo_r};
            PC_Valid <= 1'b1;
          end else begin
            WB_Data <= Mem_Rdata;
            if (stack_flags_r) begin
              Flags_Out   <= Mem_Rdata[2:0];
              Flags_Valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a behavioural 4K x 16 synchronous memory and a write log.
// Each request is issued for one accepting edge, then stall cycles are counted until Valid_Out.
// Expected values are hand-computed constants from the request stimulus.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Valid_In, MR, MW, WB, Stack_PC, Stack_Flags;
  logic [2:0]  WB_Address, Final_Flags;
  logic [31:0] Data, Address;
  logic [11:0] Mem_Addr;
  logic [15:0] Mem_Wdata, Mem_Rdata;
  logic        Mem_WE, Mem_RE, Stall, Valid_Out, WB_Out, PC_Valid, Flags_Valid;
  logic [2:0]  WB_Address_Out, Flags_Out;
  logic [15:0] WB_Data;
  logic [31:0] PC_Out;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:4095];
  logic [11:0] wlog_a [$];
  logic [15:0] wlog_d [$];

  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .Valid_In(Valid_In), .MR(MR), .MW(MW), .WB(WB),
    .WB_Address(WB_Address), .Data(Data), .Address(Address), .Stack_PC(Stack_PC),
    .Stack_Flags(Stack_Flags), .Final_Flags(Final_Flags), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_WE(Mem_WE), .Mem_RE(Mem_RE), .Mem_Rdata(Mem_Rdata),
    .Stall(Stall), .Valid_Out(Valid_Out), .WB_Out(WB_Out), .WB_Address_Out(WB_Address_Out),
    .WB_Data(WB_Data), .PC_Out(PC_Out), .PC_Valid(PC_Valid), .Flags_Out(Flags_Out),
    .Flags_Valid(Flags_Valid)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    Mem_Rdata = 16'h0;
  end

  always @(posedge clk) begin
    if (Mem_WE) begin
      mem[Mem_Addr] <= Mem_Wdata;
      wlog_a.push_back(Mem_Addr);
      wlog_d.push_back(Mem_Wdata);
    end
    if (Mem_RE) Mem_Rdata <= mem[Mem_Addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single accepting edge, then counts stall cycles up to Valid_Out.
  task automatic run_req(input logic mr, input logic mw, input logic wb, input logic [2:0] wba,
                         input logic [31:0] dat, input logic [31:0] adr, input logic spc,
                         input logic sfl, input logic [2:0] flg, input string tag,
                         input int exp_stalls);
    int  stalls;
    bit  got;
    stalls = 0;
    got    = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    Valid_In = 1'b1; MR = mr; MW = mw; WB = wb; WB_Address = wba; Data = dat;
    Address = adr; Stack_PC = spc; Stack_Flags = sfl; Final_Flags = flg;
    @(negedge clk);
    Valid_In = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (Valid_Out) begin
        got = 1'b1;
        break;
      end
      if (Stall) stalls++;
      @(negedge clk);
    end
    check({tag, "_done"}, {31'b0, got}, 32'd1);
    check({tag, "_stalls"}, stalls, exp_stalls);
  endtask

  initial begin
    rst_n = 1'b0; Valid_In = 1'b0; MR = 1'b0; MW = 1'b0; WB = 1'b0; WB_Address = 3'd0;
    Data = 32'h0; Address = 32'h0; Stack_PC = 1'b0; Stack_Flags = 1'b0; Final_Flags = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_we", {31'b0, Mem_WE}, 32'd0);
    check("rst_re", {31'b0, Mem_RE}, 32'd0);
    check("rst_vout", {31'b0, Valid_Out}, 32'd0);
    check("rst_addr", {20'b0, Mem_Addr}, 32'd0);
    rst_n = 1'b1;

    // ALU pass-through
    run_req(1'b0, 1'b0, 1'b1, 3'd7, 32'd15, 32'd0, 1'b0, 1'b0, 3'd0, "alu", 0);
    check("alu_wbdata", {16'b0, WB_Data}, 32'd15);
    check("alu_wbaddr", {29'b0, WB_Address_Out}, 32'd7);
    check("alu_wb", {31'b0, WB_Out}, 32'd1);
    check("alu_pcv", {31'b0, PC_Valid}, 32'd0);
    @(negedge clk);
    check("alu_pulse1", {31'b0, Valid_Out}, 32'd0);

    // PC push at 10
    run_req(1'b0, 1'b1, 1'b0, 3'd0, 32'h0001_0020, 32'd10, 1'b1, 1'b0, 3'd0, "push", 2);
    check("push_nw", wlog_a.size(), 32'd2);
    if (wlog_a.size() == 2) begin
      check("push_a0", {20'b0, wlog_a[0]}, 32'd10);
      check("push_d0", {16'b0, wlog_d[0]}, 32'h0001);
      check("push_a1", {20'b0, wlog_a[1]}, 32'd9);
      check("push_d1", {16'b0, wlog_d[1]}, 32'h0020);
    end
    @(negedge clk);
    check("push_pulse1", {31'b0, Valid_Out}, 32'd0);

    // PC pop at 9
    run_req(1'b1, 1'b0, 1'b1, 3'd2, 32'h0, 32'd9, 1'b1, 1'b0, 3'd0, "pop", 3);
    check("pop_pc", PC_Out, 32'h0001_0020);
    check("pop_pcv", {31'b0, PC_Valid}, 32'd1);
    check("pop_flv", {31'b0, Flags_Valid}, 32'd0);

    // Single write then single read at 20
    run_req(1'b0, 1'b1, 1'b0, 3'd0, 32'h5555_BEEF, 32'd20, 1'b0, 1'b0, 3'd0, "wr", 1);
    check("wr_nw", wlog_a.size(), 32'd1);
    check("wr_mem", {16'b0, mem[20]}, 32'hBEEF);
    run_req(1'b1, 1'b0, 1'b1, 3'd3, 32'h0, 32'd20, 1'b0, 1'b0, 3'd0, "rd", 2);
    check("rd_data", {16'b0, WB_Data}, 32'hBEEF);
    check("rd_wbaddr", {29'b0, WB_Address_Out}, 32'd3);
    check("rd_pcv", {31'b0, PC_Valid}, 32'd0);

    // Flags push then pop at 4
    run_req(1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd4, 1'b0, 1'b1, 3'b101, "fpush", 1);
    check("fpush_mem", {16'b0, mem[4]}, 32'h0005);
    run_req(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'd4, 1'b0, 1'b1, 3'b000, "fpop", 2);
    check("fpop_flags", {29'b0, Flags_Out}, 32'd5);
    check("fpop_flv", {31'b0, Flags_Valid}, 32'd1);

    // Wrap: push at 0 writes [0] then [4095]; pop at 4095 reads [4095] then [0]
    run_req(1'b0, 1'b1, 1'b0, 3'd0, 32'hA1B2_C3D4, 32'd0, 1'b1, 1'b0, 3'd0, "wpush", 2);
    check("wpush_nw", wlog_a.size(), 32'd2);
    if (wlog_a.size() == 2) begin
      check("wpush_a0", {20'b0, wlog_a[0]}, 32'd0);
      check("wpush_a1", {20'b0, wlog_a[1]}, 32'd4095);
    end
    run_req(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'd4095, 1'b1, 1'b0, 3'd0, "wpop", 3);
    check("wpop_pc", PC_Out, 32'hA1B2_C3D4);

    // MR and MW together: write only; upper address bits ignored
    run_req(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_1234, 32'hABC0_001E, 1'b0, 1'b0, 3'd0, "rw", 1);
    check("rw_nw", wlog_a.size(), 32'd1);
    check("rw_mem", {16'b0, mem[30]}, 32'h1234);

    // Stack_PC over Stack_Flags: full PC push, no flags word
    run_req(1'b0, 1'b1, 1'b0, 3'd0, 32'h0033_0044, 32'd40, 1'b1, 1'b1, 3'b111, "prio", 2);
    check("prio_hi", {16'b0, mem[40]}, 32'h0033);
    check("prio_lo", {16'b0, mem[39]}, 32'h0044);

    // Reset during WR_HI aborts the push
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    Valid_In = 1'b1; MR = 1'b0; MW = 1'b1; Stack_PC = 1'b1; Stack_Flags = 1'b0;
    Address = 32'd50; Data = 32'h7777_8888;
    @(negedge clk);
    Valid_In = 1'b0;
    check("ab_we_before", {31'b0, Mem_WE}, 32'd1);
    check("ab_addr_before", {20'b0, Mem_Addr}, 32'd50);
    rst_n = 1'b0;
    #1;
    check("ab_we_rst", {31'b0, Mem_WE}, 32'd0);
    check("ab_stall_rst", {31'b0, Stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ab_stall_after", {31'b0, Stall}, 32'd0);
    check("ab_vout_after", {31'b0, Valid_Out}, 32'd0);
    check("ab_nw", wlog_a.size(), 32'd0);
    check("ab_mem49", {16'b0, mem[49]}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The parameter ADDR_W SHALL default to 12 and set the data-memory word-address width; Address[ADDR_W-1:0] is used and the upper bits are ignored.
REQ-002 The parameter DATA_W SHALL default to 16 and set the data-memory word width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (in, 1) and rst_n (in, 1).
REQ-004 The request inputs from the EX/MEM buffer SHALL be:
- Valid_In (in, 1): request present.
- MR, MW, WB (in, 1 each): read, write and write-back controls.
- WB_Address (in, 3): destination register.
- Data (in, 32): store data, or the ALU result.
- Address (in, 32): word address or stack pointer.
- Stack_PC, Stack_Flags (in, 1 each): PC or flags stack access.
- Final_Flags (in, 3): flags as NF|CF|ZF.
REQ-005 The data-memory port SHALL be Mem_Addr (out, ADDR_W), Mem_Wdata (out, 16), Mem_WE (out, 1), Mem_RE (out, 1) and Mem_Rdata (in, 16); reads are synchronous, with data valid the cycle after Mem_RE.
REQ-006 The upstream control output SHALL be Stall (out, 1); while it is high, the ID/EX and EX/MEM buffers hold their contents.
REQ-007 The write-back outputs SHALL be:
- Valid_Out (out, 1): one-cycle result pulse.
- WB_Out (out, 1) and WB_Address_Out (out, 3).
- WB_Data (out, 16).
- PC_Out (out, 32) and PC_Valid (out, 1).
- Flags_Out (out, 3) and Flags_Valid (out, 1).

Function
REQ-008 The block SHALL use the states IDLE, WR_HI, WR_LO, RD_LO, RD_HI and RD_WAIT, and SHALL register the request fields on the accepting edge.
REQ-009 In IDLE, a rising clk edge with Valid_In=1 SHALL accept the request; Valid_In SHALL be ignored in every other state.
REQ-010 Stall SHALL equal (state != IDLE), combinationally.
REQ-011 A request with MR=0 and MW=0 SHALL stay in IDLE and, on the next cycle, SHALL pulse Valid_Out with WB_Data=Data[15:0], giving a latency of 1 and no stall.
REQ-012 A single write (MW=1, Stack_PC=0) SHALL go to WR_LO with Mem_WE=1, Mem_Addr=A and Mem_Wdata=Data[15:0], then return to IDLE.
- When Stack_Flags=1, Mem_Wdata SHALL be {13'b0, Final_Flags}.
REQ-013 A PC push (MW=1, Stack_PC=1) SHALL write in two cycles and then return to IDLE:
- WR_HI: Mem_Addr=A, Mem_Wdata=Data[31:16].
- WR_LO: Mem_Addr=A-1, Mem_Wdata=Data[15:0].
REQ-014 A single read (MR=1, Stack_PC=0) SHALL go to RD_LO with Mem_RE=1 and Mem_Addr=A, then to RD_WAIT, where it captures Mem_Rdata, then return to IDLE.
REQ-015 A PC pop (MR=1, Stack_PC=1) SHALL proceed as follows, then return to IDLE:
- RD_LO: issue a read at A.
- RD_HI: issue a read at A+1 and capture the low word.
- RD_WAIT: capture the high word.
REQ-016 The write-back result SHALL be valid the cycle after the final access state; Valid_Out SHALL be high for exactly one cycle, and WB_Out/WB_Address_Out SHALL be the registered WB/WB_Address.
REQ-017 For reads, WB_Data SHALL be the captured word.
- PC_Valid SHALL pulse with Valid_Out when Stack_PC=1, with PC_Out={hi, lo}.
- Flags_Valid SHALL pulse when Stack_Flags=1, with Flags_Out=Rdata[2:0].
REQ-018 Outside the states that drive them, Mem_WE and Mem_RE SHALL be 0, and Mem_Addr and Mem_Wdata SHALL be 0.
REQ-019 The arithmetic A+1 and A-1 SHALL be computed modulo 2^ADDR_W: A=0 minus 1 gives all ones, and all ones plus 1 gives 0.
REQ-020 When MR=1 and MW=1 together, the block SHALL perform the write and ignore the read.
REQ-021 When Stack_PC=1 and Stack_Flags=1 together, Stack_PC SHALL take priority.
REQ-022 Stall cycles per access type SHALL be: no memory access, 0; single write, 1; PC push, 2; single read, 2; PC pop, 3.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously force the state to IDLE and drive every output and internal register to 0, including Stall, Mem_WE and Mem_RE.
REQ-024 A reset asserted mid-access SHALL abort the access with no further memory cycle; after rst_n rises, the block SHALL accept only a new request.

Verification
REQ-025 ALU pass-through: MR=MW=0, WB=1, WB_Address=7, Data=15 -> Stall stays 0; the next cycle gives Valid_Out=1, WB_Data=15, WB_Address_Out=7.
REQ-026 PC push: MW=1, Stack_PC=1, Address=10, Data=0x0001_0020 -> memory writes [10]=0x0001 then [9]=0x0020; Stall is high for 2 cycles; Valid_Out pulses once.
REQ-027 PC pop: MR=1, Stack_PC=1, Address=9, memory [9]=0x0020, [10]=0x0001 -> Stall is high for 3 cycles; PC_Out=0x0001_0020 with PC_Valid=1.
REQ-028 Flags push then pop at Address=4 with Final_Flags=3'b101 -> [4]=0x0005; the pop gives Flags_Out=3'b101 with Flags_Valid=1.
REQ-029 Wrap: PC push at Address=0 -> writes go to [0] and then [4095].
REQ-030 Reset: rst_n=0 during WR_HI -> Mem_WE falls immediately; [A-1] is never written; after release, Stall=0 and Valid_Out=0.
